// File: rtl/uram_pkg.sv
// Shared defaults and request bundle for the pipelined dual-port URAM.
// Optional URAM_WRITE_FIRST_EN build switch lives in uram_dp_pipe.
package uram_pkg;

    localparam int URAM_AW_DEF  = 8;
    localparam int URAM_DW_DEF  = 32;
    localparam int URAM_LAT_DEF = 5;

    typedef struct packed {
        logic                   en;
        logic                   we;
        logic [URAM_AW_DEF-1:0] addr;
        logic [URAM_DW_DEF-1:0] data;
    } uram_req_t;

endpackage

// File: rtl/uram_rd_pipe.sv
// Valid/data read pipeline behind the array output register.
// Data stages only advance when the preceding valid bit is set.
module uram_rd_pipe #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vld_i,
    input  logic [DW-1:0] dt_i,
    output logic          vld_o,
    output logic [DW-1:0] dt_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign vld_o = vld_i;
            assign dt_o  = dt_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_q;
            logic [DW-1:0]    dt_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        dt_q[k] <= '0;
                    end
                end else begin
                    vld_q[0] <= vld_i;
                    if (vld_i) begin
                        dt_q[0] <= dt_i;
                    end
                    for (int k = 1; k < DEPTH; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        if (vld_q[k-1]) begin
                            dt_q[k] <= dt_q[k-1];
                        end
                    end
                end
            end

            assign vld_o = vld_q[DEPTH-1];
            assign dt_o  = dt_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/uram_dp_pipe.sv
// True dual-port RAM with MEM_LATENCY-cycle pipelined reads.
// Define URAM_WRITE_FIRST_EN for same-port write-first reads.
module uram_dp_pipe
    import uram_pkg::*;
#(
    parameter int MEM_AW      = URAM_AW_DEF,
    parameter int MEM_DW      = URAM_DW_DEF,
    parameter int MEM_LATENCY = URAM_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [MEM_AW-1:0] addr_a_i,
    input  logic [MEM_DW-1:0] dt_a_i,
    output logic [MEM_DW-1:0] dt_a_o,
    output logic              vld_a_o,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [MEM_AW-1:0] addr_b_i,
    input  logic [MEM_DW-1:0] dt_b_i,
    output logic [MEM_DW-1:0] dt_b_o,
    output logic              vld_b_o
);

    localparam int WORDS = 2 ** MEM_AW;

    logic [MEM_DW-1:0] mem [WORDS];

    logic [MEM_DW-1:0] rd_a_d, rd_a_q;
    logic [MEM_DW-1:0] rd_b_d, rd_b_q;
    logic              vld_a_q, vld_b_q;

`ifdef URAM_WRITE_FIRST_EN
    always_comb begin
        rd_a_d = we_a_i ? dt_a_i : mem[addr_a_i];
        rd_b_d = we_b_i ? dt_b_i : mem[addr_b_i];
    end
`else
    always_comb begin
        rd_a_d = mem[addr_a_i];
        rd_b_d = mem[addr_b_i];
    end
`endif

    // Port B is written last so it wins an address collision.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (en_a_i && we_a_i) begin
                mem[addr_a_i] <= dt_a_i;
            end
            if (en_b_i && we_b_i) begin
                mem[addr_b_i] <= dt_b_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            vld_a_q <= en_a_i;
            vld_b_q <= en_b_i;
            if (en_a_i) begin
                rd_a_q <= rd_a_d;
            end
            if (en_b_i) begin
                rd_b_q <= rd_b_d;
            end
        end
    end

    uram_rd_pipe #(
        .DW    (MEM_DW),
        .DEPTH (MEM_LATENCY - 1)
    ) u_pipe_a (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vld_i (vld_a_q),
        .dt_i  (rd_a_q),
        .vld_o (vld_a_o),
        .dt_o  (dt_a_o)
    );

    uram_rd_pipe #(
        .DW    (MEM_DW),
        .DEPTH (MEM_LATENCY - 1)
    ) u_pipe_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vld_i (vld_b_q),
        .dt_i  (rd_b_q),
        .vld_o (vld_b_o),
        .dt_o  (dt_b_o)
    );

endmodule

// File: tb/tb_uram_dp_pipe.sv
// Self-checking bench for uram_dp_pipe against a queue-based model.
// Honours URAM_WRITE_FIRST_EN when the design is built with it.
module tb_uram_dp_pipe;
    import uram_pkg::*;

    localparam int AW = URAM_AW_DEF;
    localparam int DW = URAM_DW_DEF;
    localparam int L  = URAM_LAT_DEF;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_a = 1'b0, we_a = 1'b0;
    logic          en_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic [DW-1:0] dt_a, dt_b;
    logic          vld_a, vld_b;

    logic [DW-1:0] ref_mem [2**AW];
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] last_a = '0, last_b = '0;
    int            cyc_n = 0;
    int            vld_b_cnt = 0;
    int            vld_b_at = -1;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    uram_dp_pipe dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_a_i   (en_a),
        .we_a_i   (we_a),
        .addr_a_i (addr_a),
        .dt_a_i   (din_a),
        .dt_a_o   (dt_a),
        .vld_a_o  (vld_a),
        .en_b_i   (en_b),
        .we_b_i   (we_b),
        .addr_b_i (addr_b),
        .dt_b_i   (din_b),
        .dt_b_o   (dt_b),
        .vld_b_o  (vld_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic uram_req_t rq(input logic e, input logic w,
                                     input int a, input logic [DW-1:0] d);
        uram_req_t r;
        r.en   = e;
        r.we   = w;
        r.addr = AW'(a);
        r.data = d;
        return r;
    endfunction

    function automatic logic [DW-1:0] rd_val(input uram_req_t r);
`ifdef URAM_WRITE_FIRST_EN
        if (r.we) return r.data;
`endif
        return ref_mem[r.addr];
    endfunction

    task automatic cyc(input uram_req_t a, input uram_req_t b,
                       input logic r);
        exp_t e;
        rst    = r;
        en_a   = a.en;
        we_a   = a.we;
        addr_a = a.addr;
        din_a  = a.data;
        en_b   = b.en;
        we_b   = b.we;
        addr_b = b.addr;
        din_b  = b.data;
        @(posedge clk);
        if (r) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
        end else begin
            if (a.en) begin
                e.due = cyc_n + L - 1;
                e.d   = rd_val(a);
                qa.push_back(e);
            end
            if (b.en) begin
                e.due = cyc_n + L - 1;
                e.d   = rd_val(b);
                qb.push_back(e);
            end
            if (a.en && a.we) ref_mem[a.addr] = a.data;
            if (b.en && b.we) ref_mem[b.addr] = b.data;
        end
        #1;
        if (qa.size() > 0 && qa[0].due == cyc_n) begin
            e = qa.pop_front();
            last_a = e.d;
            chk("vld_a", DW'(vld_a), 1);
            chk("dt_a", dt_a, e.d);
        end else begin
            chk("vld_a_idle", DW'(vld_a), 0);
            chk("dt_a_hold", dt_a, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc_n) begin
            e = qb.pop_front();
            last_b = e.d;
            chk("vld_b", DW'(vld_b), 1);
            chk("dt_b", dt_b, e.d);
        end else begin
            chk("vld_b_idle", DW'(vld_b), 0);
            chk("dt_b_hold", dt_b, last_b);
        end
        if (vld_b) begin
            vld_b_cnt++;
            vld_b_at = cyc_n;
        end
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(rq(0, 0, 0, 0), rq(0, 0, 0, 0), 0);
    endtask

    initial begin
        uram_req_t z;
        uram_req_t ra;
        uram_req_t rb;
        int issue;
        int base;
        z = rq(0, 0, 0, 0);
        for (int i = 0; i < 2**AW; i++) begin
            dut.mem[i] = DW'(i);
            ref_mem[i] = DW'(i);
        end

        for (int i = 0; i < 8; i++) cyc(z, z, 1);
        chk("rst_dt_a", dt_a, 0);
        chk("rst_dt_b", dt_b, 0);

        base  = vld_b_cnt;
        issue = cyc_n;
        cyc(z, rq(1, 0, 5, 0), 0);
        idle(L + 2);
        chk("rd5_data", dt_b, 5);
        chk("rd5_pulses", DW'(vld_b_cnt - base), 1);
        chk("rd5_lat", DW'(vld_b_at - issue), DW'(L - 1));

        for (int i = 0; i < 16; i++) cyc(rq(1, 1, i, DW'(i + 1)), z, 0);
        base = vld_b_cnt;
        for (int i = 0; i < 16; i++) cyc(z, rq(1, 0, i, 0), 0);
        idle(L);
        chk("b2b_pulses", DW'(vld_b_cnt - base), 16);
        chk("b2b_last", dt_b, 16);

        base = vld_b_cnt;
        for (int i = 0; i < 8; i++) cyc(z, rq(i % 2, 0, 20 + i / 2, 0), 0);
        idle(L);
        chk("tog_pulses", DW'(vld_b_cnt - base), 4);
        chk("tog_last", dt_b, 23);

        base = vld_b_cnt;
        for (int i = 0; i < 3; i++) cyc(z, rq(1, 0, i, 0), 0);
        idle(1);
        cyc(rq(1, 1, 0, 'hDEAD), z, 1);
        idle(L + 2);
        chk("flush_pulses", DW'(vld_b_cnt - base), 0);
        chk("flush_dt", dt_b, 0);
        for (int i = 0; i < 16; i++) cyc(z, rq(1, 0, i, 0), 0);
        idle(L);
        chk("keep_last", dt_b, 16);

        cyc(rq(1, 1, 7, 'hAAAA), rq(1, 1, 7, 'hBBBB), 0);
        cyc(z, rq(1, 0, 7, 0), 0);
        idle(L);
        chk("coll_ww", dt_b, 'hBBBB);

        cyc(rq(1, 1, 3, 'h1234), rq(1, 0, 3, 0), 0);
        idle(L);
        chk("coll_wr", dt_b, 4);

        cyc(rq(1, 1, 9, 'hCAFE), z, 0);
        idle(L);
`ifdef URAM_WRITE_FIRST_EN
        chk("same_port", dt_a, 'hCAFE);
`else
        chk("same_port", dt_a, 10);
`endif

        for (int i = 0; i < 400; i++) begin
            ra = rq($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 31), DW'($urandom));
            rb = rq($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 31), DW'($urandom));
            cyc(ra, rb, $urandom_range(0, 49) == 0);
        end
        idle(L + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uram_dp_pipe.md
Name: uram_dp_pipe

Overview:
- Single-clock true dual-port RAM with pipelined synchronous reads, sized for UltraRAM inference.
- Two symmetric ports, A and B. Each port has its own enable, write enable, address, write data and read data.
- The read pipeline depth is a parameter.
- The degenerate uses are built from this block by tying inputs: simple dual-port (A writes, B reads), and no-enable variants (en tied 1).

Parameters:
- MEM_AW, 8: address width; depth is 2**MEM_AW words.
- MEM_DW, 32: data width.
- MEM_LATENCY, 5: read latency in clock cycles; legal range 1..16.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_a_i  in  1  port A access enable.
- we_a_i  in  1  port A write enable; qualified by en_a_i.
- addr_a_i  in  MEM_AW  port A address.
- dt_a_i  in  MEM_DW  port A write data.
- dt_a_o  out  MEM_DW  port A read data.
- vld_a_o  out  1  port A read data valid, 1-cycle pulse per read.
- en_b_i, we_b_i, addr_b_i, dt_b_i, dt_b_o, vld_b_o: same as port A, for port B.

Behaviour:
- Storage:
  - Array named mem, 2**MEM_AW x MEM_DW.
  - Simulators may preload it by hierarchical reference (mem[i]).
  - No reset of contents; initial contents are undefined unless preloaded.
- Write: at a rising edge with en_x_i=1 and we_x_i=1, mem[addr_x_i] <= dt_x_i. No write when en_x_i=0.
- Read issue: every edge with en_x_i=1 issues a read of addr_x_i, including write cycles.
- Read timing: data issued at edge N appears on dt_x_o after edge N+MEM_LATENCY-1 and is stable for the whole following cycle. Total latency is MEM_LATENCY cycles counted from the sampling edge.
- Read data source: default is read-first, i.e. the pre-write contents (see Optional Feature).
- Pipeline structure:
  - Stage 0 is the array output register.
  - Stages 1..MEM_LATENCY-1 are data registers.
  - A parallel valid shift register moves every cycle regardless of enables.
  - Data stage k loads from stage k-1 only when valid stage k-1 is set; otherwise it holds.
- Output hold: dt_x_o holds the last valid read word indefinitely while no new reads complete. vld_x_o is high exactly for the cycle in which new data is presented.
- Back-to-back reads: one result per cycle, in order, with no bubbles.
- Reset:
  - rst_i=1 at an edge clears all valid bits and pipeline data registers, so dt_x_o=0 and vld_x_o=0 the next cycle.
  - In-flight reads are discarded; memory contents are unchanged.
  - Writes presented in the reset cycle are ignored.
- Cross-port read of an address being written by the other port in the same cycle: returns old data.
- Both ports writing the same address in the same cycle: port B data is stored.
- MEM_LATENCY=1: only the stage-0 register exists.

Optional Feature:
- Macro URAM_WRITE_FIRST_EN.
- Defined: a port that writes and reads the same address in the same cycle returns the newly written dt_x_i (write-first). Cross-port reads remain read-first.
- Undefined (default): read-first on both ports; the old word is returned.

Decomposition:
- Package uram_pkg holds:
  - localparam defaults (URAM_AW_DEF=8, URAM_DW_DEF=32, URAM_LAT_DEF=5);
  - typedef of the per-port request struct {en, we, addr, data}.
- One sub-module, uram_rd_pipe: a parameterised valid/data pipeline of depth MEM_LATENCY-1, instantiated once per port.
- The array and write logic stay in the top module.

Test Plan:
- Preload mem[i]=i for all 256 entries. Hold rst_i=1 for 8 cycles and check dt_a_o=dt_b_o=0 and vld=0. Release rst_i, read B at address 5 with en_b_i=1 for one cycle, and check dt_b_o=5 with a single vld_b_o pulse exactly 5 cycles after the issuing edge.
- Write A at addresses 0..15 with data addr+1, one per cycle. Then read B at addresses 0..15 back-to-back and check dt_b_o = 1..16 on consecutive cycles starting at latency 5, with vld_b_o high for 16 cycles.
- Read B with en_b_i toggling 0,1,0,1 while the address advances every 2 cycles. Check only enabled reads appear after 5 cycles, and dt_b_o holds the previous value between them.
- Issue 3 reads, then assert rst_i 2 cycles later. Check no vld_b_o pulses occur and dt_b_o=0. Check that mem[0..15] still read back as 1..16 afterwards.
- Collision case 1: A writes 0xAAAA and B writes 0xBBBB to address 7 in the same cycle; a later read returns 0xBBBB.
- Collision case 2: A writes 0x1234 to address 3 while B reads address 3 in the same cycle; B returns the old value 4.
- Same-port write+read of address 9 with data 0xCAFE: without the macro, A returns the old value 10; with URAM_WRITE_FIRST_EN defined, A returns 0xCAFE.
